// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized, oversampled deframer assembling NUM_WORDS packets into one valid/ready word.
// Optional stop-bit checking with a frame_err pulse is enabled by defining UART_RX_FRAME_CHECK_EN.
module uart_rx #(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned PACKET_SIZE      = BITS_PER_WORD + 5,
  parameter int unsigned W_OUT            = 16
) (
  input  logic                                               clk,
  input  logic                                               rstn,
  input  logic                                               rx,
  output logic [W_OUT/BITS_PER_WORD-1:0][BITS_PER_WORD-1:0]  m_data,
  output logic                                               m_valid,
  input  logic                                               m_ready,
  output logic                                               overflow
`ifdef UART_RX_FRAME_CHECK_EN
  ,
  output logic                                               frame_err
`endif
);

  localparam int unsigned NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int unsigned END_BITS  = PACKET_SIZE - BITS_PER_WORD - 1;
  localparam int unsigned CW        = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BW        = $clog2(BITS_PER_WORD + 1);
  localparam int unsigned WW        = ($clog2(NUM_WORDS + 1) < 1) ? 1 : $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, END} state_t;

  state_t                                      state, state_n;
  logic                                        rx_q, rx_s;
  logic [CW-1:0]                               c_clocks, c_clocks_n;
  logic [BW-1:0]                               c_bits, c_bits_n;
  logic [WW-1:0]                               c_words, c_words_n;
  logic [BITS_PER_WORD-1:0]                    shreg, shreg_n;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]     asm_buf, asm_n;
  logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]     m_data_n;
  logic                                        m_valid_n, overflow_n;
  logic                                        done, done_n;
`ifdef UART_RX_FRAME_CHECK_EN
  logic                                        bad, bad_n, frame_err_n;
`endif

  // Register stage: synchronizer, FSM state, counters, buffers and outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_q      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      c_clocks  <= '0;
      c_bits    <= '0;
      c_words   <= '0;
      shreg     <= '0;
      asm_buf   <= '0;
      done      <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      overflow  <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
      bad       <= 1'b0;
      frame_err <= 1'b0;
`endif
    end else begin
      rx_q      <= rx;
      rx_s      <= rx_q;
      state     <= state_n;
      c_clocks  <= c_clocks_n;
      c_bits    <= c_bits_n;
      c_words   <= c_words_n;
      shreg     <= shreg_n;
      asm_buf   <= asm_n;
      done      <= done_n;
      m_data    <= m_data_n;
      m_valid   <= m_valid_n;
      overflow  <= overflow_n;
`ifdef UART_RX_FRAME_CHECK_EN
      bad       <= bad_n;
      frame_err <= frame_err_n;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state;
    c_clocks_n = c_clocks;
    c_bits_n   = c_bits;
    c_words_n  = c_words;
    shreg_n    = shreg;
    asm_n      = asm_buf;
    done_n     = 1'b0;
    m_data_n   = m_data;
    m_valid_n  = m_valid;
    overflow_n = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
    bad_n       = bad;
    frame_err_n = 1'b0;
`endif

    if (m_valid && m_ready) m_valid_n = 1'b0;
    // A completed group loads only when the output slot is free or being consumed
    if (done) begin
      if (!m_valid || m_ready) begin
        m_data_n  = asm_buf;
        m_valid_n = 1'b1;
      end else begin
        overflow_n = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n    = START;
          c_clocks_n = '0;
        end
      end
      START: begin
        if (c_clocks == CW'(CLOCKS_PER_PULSE / 2 - 1)) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n    = DATA;
            c_clocks_n = '0;
            c_bits_n   = '0;
          end
        end else begin
          c_clocks_n = c_clocks + CW'(1);
        end
      end
      DATA: begin
        if (c_clocks == CW'(CLOCKS_PER_PULSE - 1)) begin
          shreg_n    = {rx_s, shreg[BITS_PER_WORD-1:1]};
          c_clocks_n = '0;
          if (c_bits == BW'(BITS_PER_WORD - 1)) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (c_words == WW'(i)) asm_n[i] = shreg_n;
            end
            state_n  = END;
            c_bits_n = '0;
`ifdef UART_RX_FRAME_CHECK_EN
            bad_n = 1'b0;
`endif
          end else begin
            c_bits_n = c_bits + BW'(1);
          end
        end else begin
          c_clocks_n = c_clocks + CW'(1);
        end
      end
      END: begin
        if (c_clocks == CW'(CLOCKS_PER_PULSE - 1)) begin
          c_clocks_n = '0;
`ifdef UART_RX_FRAME_CHECK_EN
          bad_n = bad | ~rx_s;
`endif
          if (c_bits == BW'(END_BITS - 1)) begin
            state_n  = IDLE;
            c_bits_n = '0;
`ifdef UART_RX_FRAME_CHECK_EN
            if (bad || !rx_s) begin
              c_words_n   = '0;
              frame_err_n = 1'b1;
            end else
`endif
            if (c_words == WW'(NUM_WORDS - 1)) begin
              c_words_n = '0;
              done_n    = 1'b1;
            end else begin
              c_words_n = c_words + WW'(1);
            end
          end else begin
            c_bits_n = c_bits + BW'(1);
          end
        end else begin
          c_clocks_n = c_clocks + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed groups, glitch, backpressure, mid-frame reset.
module tb_uart_rx;

  localparam int unsigned CPP = 4;
  localparam int unsigned BPW = 8;
  localparam int unsigned WO  = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx;
  logic [1:0][7:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          overflow;
`ifdef UART_RX_FRAME_CHECK_EN
  logic          frame_err;
  int            ferr_count = 0;
`endif

  int            checks = 0;
  int            errors = 0;
  int            ovf_count = 0;
  logic          ovf_prev = 1'b0;
  logic [15:0]   exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (BPW),
    .PACKET_SIZE     (BPW + 5),
    .W_OUT           (WO)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx      (rx),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .overflow(overflow)
`ifdef UART_RX_FRAME_CHECK_EN
    ,
    .frame_err(frame_err)
`endif
  );

  // Monitor: every accepted word is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (rstn) begin
      if (overflow) ovf_count++;
      if (overflow && ovf_prev) begin
        errors++;
        $display("FAIL overflow_width: overflow high 2+ cycles, required 1-cycle pulse");
      end
      ovf_prev = overflow;
`ifdef UART_RX_FRAME_CHECK_EN
      if (frame_err) ferr_count++;
`endif
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h, required no output", m_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL word: got %h, required %h", m_data, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPP) @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input logic [7:0] b, input logic [3:0] stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    for (int i = 0; i < 4; i++) drive_bit(stop[i]);
  endtask

  task automatic send_group(input logic [15:0] w);
    send_packet(w[7:0], 4'hF);
    send_packet(w[15:8], 4'hF);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!m_valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_valid_timeout", 32'(m_valid), 32'd1);
  endtask

  initial begin
    int ovf_before;
    rstn    = 1'b0;
    rx      = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_m_data", 32'(m_data), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    rstn = 1'b1;
    idle(4);

    // Nominal back-to-back packets
    exp_q.push_back(16'h3CA5);
    send_packet(8'hA5, 4'hF);
    send_packet(8'h3C, 4'hF);
    idle(12);
    check("nominal_no_overflow", 32'(ovf_count), 32'd0);

    // One-clock glitch must be rejected as a false start
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(20);
    check("glitch_no_valid", 32'(m_valid), 32'd0);
    exp_q.push_back(16'hBEEF);
    send_group(16'hBEEF);
    idle(12);

    // Backpressure: second group dropped, first held
    m_ready = 1'b0;
    exp_q.push_back(16'h1111);
    ovf_before = ovf_count;
    send_group(16'h1111);
    wait_valid(20);
    send_group(16'h2222);
    idle(12);
    check("bp_overflow_once", 32'(ovf_count - ovf_before), 32'd1);
    check("bp_data_held", 32'(m_data), 32'h1111);
    check("bp_valid_held", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_drop", 32'(m_valid), 32'd0);
    idle(4);

    // Mid-frame reset while an unconsumed word is held
    m_ready = 1'b0;
    send_group(16'h5A5A);
    wait_valid(20);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rstn = 1'b0;
    #1;
    check("midreset_m_valid", 32'(m_valid), 32'd0);
    check("midreset_m_data", 32'(m_data), 32'd0);
    check("midreset_overflow", 32'(overflow), 32'd0);
    rx = 1'b1;
    idle(3);
    rstn    = 1'b1;
    m_ready = 1'b1;
    idle(4);
    exp_q.push_back(16'h00FF);
    send_group(16'h00FF);
    idle(12);

    // Back-to-back groups with edge patterns
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h8001);
    send_group(16'h0000);
    send_group(16'hFFFF);
    send_group(16'h8001);
    idle(12);

`ifdef UART_RX_FRAME_CHECK_EN
    // Bad second stop bit of packet 1 discards the group
    send_packet(8'h12, 4'hF);
    send_packet(8'h34, 4'b1101);
    idle(12);
    check("frame_err_pulse", 32'(ferr_count), 32'd1);
    check("frame_err_no_valid", 32'(m_valid), 32'd0);
    exp_q.push_back(16'hCAFE);
    send_group(16'hCAFE);
    idle(12);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("total_overflow", 32'(ovf_count), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench never hangs
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
